data_array_port_ctrl: RTL and testbench



---
 rtl/data_array_port_ctrl.sv | 162 ++++++++++++++++
 tb/tb_data_array_port_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_array_port_ctrl.sv
// rtl/data_array_port_ctrl.sv - requester-side port controller for a 1RW byte-masked data-array SRAM macro
//
// Purpose: accepts read/write requests, drives the macro pins combinationally,
// captures the macro's one-cycle-late read data into a response FIFO and
// returns it in request order.
// Optional feature macro: DATA_ARRAY_CLEAR_EN (power-up sweep that zeroes the array).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid_i/req_ready_o         request handshake
//   req_we_i, req_addr_i            1=write/0=read, word address
//   req_wmask_i, req_wdata_i        byte enables and write data
//   resp_valid_o/resp_ready_i       read response handshake
//   resp_rdata_o                    read data, in request order
//   init_done_o                     controller is accepting requests
//   sram_csb_o, sram_web_o          macro chip select / write enable, active low
//   sram_wmask_o, sram_addr_o       macro byte mask / address
//   sram_din_o, sram_dout_i         macro write data / read data (one cycle late)
module data_array_port_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 256,
  parameter int NUM_WMASKS = DATA_WIDTH / 8,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_WMASKS-1:0] req_wmask_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  init_done_o,
  output logic                  sram_csb_o,
  output logic                  sram_web_o,
  output logic [NUM_WMASKS-1:0] sram_wmask_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_din_o,
  input  logic [DATA_WIDTH-1:0] sram_dout_i
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

`ifdef DATA_ARRAY_CLEAR_EN
  localparam state_e RESET_STATE = CLEAR;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
`else
  localparam state_e RESET_STATE = RUN;
`endif

  state_e                state_q, state_d;
  logic                  init_done_q, init_done_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] fifo_q [RESP_DEPTH];
  logic                  push, pop, fire;
  logic [CNT_W:0]        occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign resp_valid_o  = (count_q != '0);
  assign resp_rdata_o  = fifo_q[rd_ptr_q];
  assign init_done_o   = init_done_q;
  assign pop           = resp_valid_o && resp_ready_i;
  // Data from a read issued last cycle is on sram_dout_i now.
  assign push          = rd_inflight_q;
  // Slots already committed: queued responses plus the read in flight,
  // minus the one leaving this cycle.
  assign occupancy     = {1'b0, count_q} + (CNT_W+1)'(rd_inflight_q) - (CNT_W+1)'(pop);
  assign count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
  assign rd_inflight_d = fire && !req_we_i;

  always_comb begin
    state_d      = state_q;
    init_done_d  = init_done_q;
    req_ready_o  = 1'b0;
    fire         = 1'b0;
    sram_csb_o   = 1'b1;
    sram_web_o   = 1'b1;
    sram_wmask_o = '0;
    sram_addr_o  = '0;
    sram_din_o   = '0;
`ifdef DATA_ARRAY_CLEAR_EN
    sweep_d      = sweep_q;
`endif
    case (state_q)
      CLEAR: begin
`ifdef DATA_ARRAY_CLEAR_EN
        // rst_n qualifies the sweep so the pins idle while reset is held.
        if (rst_n) begin
          sram_csb_o   = 1'b0;
          sram_web_o   = 1'b0;
          sram_wmask_o = '1;
          sram_addr_o  = sweep_q;
          sweep_d      = sweep_q + 1'b1;
          if (sweep_q == '1) begin
            state_d     = RUN;
            init_done_d = 1'b1;
          end
        end
`else
        state_d = RUN;
`endif
      end
      RUN: begin
        init_done_d = 1'b1;
        req_ready_o = init_done_q && (occupancy < (CNT_W+1)'(RESP_DEPTH));
        fire        = req_valid_i && req_ready_o;
        sram_csb_o  = !fire;
        sram_web_o  = !(fire && req_we_i);
        // init_done_q is cleared by reset, so the pins go idle asynchronously.
        if (init_done_q) begin
          sram_wmask_o = req_wmask_i;
          sram_addr_o  = req_addr_i;
          sram_din_o   = req_wdata_i;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RESET_STATE;
      init_done_q   <= 1'b0;
      rd_inflight_q <= 1'b0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
`ifdef DATA_ARRAY_CLEAR_EN
      sweep_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      init_done_q   <= init_done_d;
      rd_inflight_q <= rd_inflight_d;
      count_q       <= count_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
`ifdef DATA_ARRAY_CLEAR_EN
      sweep_q       <= sweep_d;
`endif
    end
  end

  // Storage only; validity is tracked by count_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= sram_dout_i;
  end

endmodule

// File: tb/tb_data_array_port_ctrl.sv
// tb/tb_data_array_port_ctrl.sv - self-checking bench for data_array_port_ctrl
module tb_data_array_port_ctrl;
  localparam int AW = 5, DW = 256, NM = 32, DEPTH = 2, WORDS = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [NM-1:0] req_wmask = '0;
  logic [DW-1:0] req_wdata = '0;
  logic req_ready, resp_valid, init_done, sram_csb, sram_web;
  logic [DW-1:0] resp_rdata, sram_din, sram_dout;
  logic [NM-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;

  always #5 clk = ~clk;

  data_array_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NM), .RESP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wmask_i(req_wmask), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
    .init_done_o(init_done), .sram_csb_o(sram_csb), .sram_web_o(sram_web),
    .sram_wmask_o(sram_wmask), .sram_addr_o(sram_addr), .sram_din_o(sram_din),
    .sram_dout_i(sram_dout)
  );

  // SRAM macro model: masked write, read data one cycle later.
  logic [DW-1:0] sram_mem [WORDS];
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) begin
        for (int b = 0; b < NM; b++)
          if (sram_wmask[b]) sram_mem[sram_addr][b*8 +: 8] = sram_din[b*8 +: 8];
      end else begin
        sram_dout <= sram_mem[sram_addr];
      end
    end
  end

  // Reference: array contents, expected responses in order, and the edge
  // count at which each response becomes visible.
  logic [DW-1:0] ref_mem [WORDS];
  logic [DW-1:0] exp_q [$];
  int rdy_q [$];
  int edge_n = 0;
  bit init_ok = 0;
  int n_cmp = 0, n_mis = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check before the edge, update model after it.
  task automatic cyc(input logic v, input logic we, input logic [AW-1:0] a,
                     input logic [NM-1:0] m, input logic [DW-1:0] d,
                     input logic rr, output logic fired);
    logic exp_rv, exp_pop, exp_rdy;
    int occ;
    req_valid = v; req_we = we; req_addr = a; req_wmask = m; req_wdata = d; resp_ready = rr;
    #1;
    exp_rv  = (exp_q.size() > 0) && (rdy_q[0] <= edge_n);
    exp_pop = exp_rv && rr;
    occ     = exp_q.size() - (exp_pop ? 1 : 0);
    exp_rdy = init_ok && (occ < DEPTH);
    chk1("resp_valid", resp_valid, exp_rv);
    chk1("req_ready", req_ready, exp_rdy);
    if (exp_rv) chkw("resp_rdata", resp_rdata, exp_q[0]);
    fired = v && exp_rdy;
    chk1("sram_csb", sram_csb, !fired);
    chk1("sram_web", sram_web, !(fired && we));
    if (fired) chkw("sram_addr", DW'(sram_addr), DW'(a));
    if (dut.rd_inflight_q) chk1("no_push_when_full", dut.count_q < DEPTH, 1'b1);
    @(posedge clk);
    edge_n++;
    if (exp_pop) begin
      void'(exp_q.pop_front());
      void'(rdy_q.pop_front());
    end
    if (fired) begin
      if (we) begin
        for (int b = 0; b < NM; b++)
          if (m[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        exp_q.push_back(ref_mem[a]);
        rdy_q.push_back(edge_n + 1);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_wmask = '0; req_wdata = '0;
    exp_q.delete(); rdy_q.delete(); init_ok = 0;
    #1;
    chk1("rst_req_ready", req_ready, 1'b0);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk1("rst_init_done", init_done, 1'b0);
    chk1("rst_csb", sram_csb, 1'b1);
    chk1("rst_web", sram_web, 1'b1);
    chkw("rst_wmask", DW'(sram_wmask), '0);
    chkw("rst_addr", DW'(sram_addr), '0);
    chkw("rst_din", sram_din, '0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef DATA_ARRAY_CLEAR_EN
    for (int i = 0; i < WORDS; i++) begin
      #1;
      chk1("clr_csb", sram_csb, 1'b0);
      chk1("clr_web", sram_web, 1'b0);
      chkw("clr_addr", DW'(sram_addr), DW'(i));
      chkw("clr_wmask", DW'(sram_wmask), {DW{1'b0}} | {NM{1'b1}});
      chkw("clr_din", sram_din, '0);
      chk1("clr_req_ready", req_ready, 1'b0);
      chk1("clr_init_done", init_done, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
`else
    #1;
    chk1("pre_init_done", init_done, 1'b0);
    @(posedge clk);
    @(negedge clk);
`endif
    chk1("init_done", init_done, 1'b1);
    init_ok = 1;
  endtask

  initial begin
    logic f;
    int idx;
    bit done;
    logic [DW-1:0] pat_a5, pat_11, pat_ff, pat_merge, rnd;
    pat_a5 = {32{8'hA5}};
    pat_11 = {32{8'h11}};
    pat_ff = {8{32'hDEADBEFF}};
    pat_merge = {{31{8'h11}}, 8'hFF};

    for (int i = 0; i < WORDS; i++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      sram_mem[i] = rnd;
      ref_mem[i] = rnd;
    end

    do_reset();

    // Every word readable after init (all zero when the sweep is enabled).
    for (int i = 0; i < WORDS; i++) cyc(1, 0, AW'(i), '0, '0, 1, f);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, '0, '0, 1, f);

    // Write then read addr 3, checking the 2-edge latency explicitly.
    cyc(1, 1, 5'd3, '1, pat_a5, 1, f);
    cyc(1, 0, 5'd3, '0, '0, 0, f);
    #1 chk1("t1_not_yet_valid", resp_valid, 1'b0);
    cyc(0, 0, '0, '0, '0, 0, f);
    #1 chkw("t1_rdata", resp_rdata, pat_a5);
    cyc(0, 0, '0, '0, '0, 1, f);

    // Partial-mask write merges into the existing word.
    cyc(1, 1, 5'd7, '1, pat_11, 1, f);
    cyc(1, 1, 5'd7, 32'h1, pat_ff, 1, f);
    cyc(1, 0, 5'd7, '0, '0, 0, f);
    cyc(0, 0, '0, '0, '0, 0, f);
    #1 chkw("t2_merge", resp_rdata, pat_merge);
    cyc(0, 0, '0, '0, '0, 1, f);

    // Eight back-to-back reads with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, AW'(i), '0, '0, 1, f);
      chk1("t3_accept", f, 1'b1);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, '0, '0, 1, f);

    // Stalled consumer: only DEPTH reads fit, then drain and finish.
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      cyc(1, 0, AW'(idx + 10), '0, '0, 0, f);
      if (f) idx++;
    end
    chkw("t4_accepted_stalled", DW'(idx), DW'(2));
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      cyc(idx < 4, 0, AW'(idx + 10), '0, '0, 1, f);
      if (f) idx++;
      if (idx == 4 && exp_q.size() == 0) done = 1;
    end
    chk1("t4_drained", done, 1'b1);

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      cyc(($urandom % 4) != 0, $urandom % 2, AW'($urandom % WORDS), NM'($urandom),
          {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()},
          ($urandom % 4) != 0, f);
    end
    for (int c = 0; c < 4; c++) cyc(0, 0, '0, '0, '0, 1, f);

    // Reset with one response queued and one read in flight.
    cyc(1, 0, 5'd3, '0, '0, 0, f);
    cyc(1, 0, 5'd7, '0, '0, 0, f);
    req_valid = 1'b1; req_we = 1'b0;
    rst_n = 1'b0;
    #1;
    chk1("t6_resp_valid", resp_valid, 1'b0);
    chk1("t6_csb", sram_csb, 1'b1);
    chk1("t6_req_ready", req_ready, 1'b0);
    @(negedge clk);
    do_reset();
    for (int c = 0; c < 4; c++) cyc(0, 0, '0, '0, '0, 1, f);
    cyc(1, 0, 5'd7, '0, '0, 1, f);
    for (int c = 0; c < 3; c++) cyc(0, 0, '0, '0, '0, 1, f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
